mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data/instruction RAM between the CPU (fsm mem_cmd/addr path) and a
//  second requester (DMA / debug loader) using a valid/grant handshake. CPU has default priority;
//  a starvation counter and an optional locked DMA burst mode bound the wait time of each side.
//  Sits between the CPU memory interface and the RAM; the CPU holds its state while cpu_stall=1.
// PARAMETERS
//  ADDR_W     9   RAM address width
//  DATA_W     16  RAM data width
//  RD_LAT     1   RAM read latency in cycles (>=1); data valid RD_LAT cycles after address
//  STARVE_MAX 4   consecutive CPU wins while DMA waits before DMA is forced through
//  BURST_MAX  8   max consecutive DMA grants in locked burst before one forced CPU slot
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  cpu_mem_cmd in  2       MNONE=00, MREAD=01, MWRITE=10 (11 treated as MNONE)
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  read data to CPU (combinational from ram_rdata)
//  cpu_stall  out  1       CPU request present but not granted this cycle
//  dma_req    in   1       DMA request; held stable with fields until dma_gnt
//  dma_we     in   1       1=write, 0=read
//  dma_lock   in   1       request locked burst; sampled with dma_req
//  dma_addr   in   ADDR_W  DMA address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_gnt    out  1       one-cycle pulse: DMA access issued to RAM this cycle
//  dma_rvalid out  1       one-cycle pulse RD_LAT cycles after a DMA read grant
//  dma_rdata  out  DATA_W  read data, valid with dma_rvalid
//  ram_addr   out  ADDR_W  RAM address
//  ram_we     out  1       RAM write enable
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data
// BEHAVIOUR
//  - Reset: state=ARB, starve_cnt=0, burst_cnt=0, read pipe cleared; dma_gnt, dma_rvalid,
//    ram_we, cpu_stall=0; ram_addr/ram_wdata=0. In-flight DMA reads are dropped (no rvalid).
//  - One RAM access per cycle; grant decision combinational from current requests + state.
//  - ARB: cpu_req only -> CPU; dma_req only -> DMA; both -> CPU unless starve_cnt==STARVE_MAX,
//    then DMA. starve_cnt increments on each CPU win with dma_req high, clears on any DMA grant
//    or when dma_req low; saturates at STARVE_MAX.
//  - DMA grant with dma_lock=1 -> next state DMA_BURST, burst_cnt=1.
//  - DMA_BURST: DMA owns port while dma_req&dma_lock; CPU stalled. burst_cnt++ per grant; at
//    BURST_MAX -> CPU_SLOT. dma_lock or dma_req low -> ARB, burst_cnt=0.
//  - CPU_SLOT: one cycle, CPU priority regardless of starve_cnt; DMA not granted; -> DMA_BURST
//    (burst_cnt=0) if dma_req&dma_lock else ARB. No CPU request in slot: slot still consumed.
//  - CPU grant: ram_addr=cpu_addr, ram_we=(cmd==MWRITE), ram_wdata=cpu_wdata, cpu_stall=0.
//  - DMA grant: ram_* from dma_*, dma_gnt=1; cpu_stall=1 iff CPU request present.
//  - No grant: ram_we=0, ram_addr holds CPU address (keeps IF timing of CPU unchanged).
//  - DMA reads: RD_LAT-deep valid shift register; dma_rdata=ram_rdata when dma_rvalid=1.
//    Back-to-back DMA reads give back-to-back rvalid pulses in issue order.
//  - CPU reads need no tag: CPU holds cmd/addr while stalled and samples on its own timing.
//  - Write to same address by both in one cycle impossible (single grant); no merging.
// STRUCTURE
//  - Shared package mem_pkg: MNONE/MREAD/MWRITE constants (replacing local defines), arb_state_t
//    enum {ARB, DMA_BURST, CPU_SLOT}.
//  - Sub-module rd_lat_pipe #(RD_LAT): valid shift register for DMA read return.
// TESTING
//  - Reset held 2 cycles during DMA read in flight -> no dma_rvalid, all outputs 0 after reset.
//  - cpu MREAD addr 5 alone -> ram_addr=5, ram_we=0, cpu_stall=0; dma_req alone we=1 addr 9
//    data 0xBEEF -> dma_gnt pulse, ram_we=1, mem[9]=0xBEEF.
//  - CPU MREAD every cycle + dma_req held: CPU wins 4 cycles, DMA granted 5th cycle,
//    cpu_stall=1 exactly that cycle; pattern repeats.
//  - dma_lock burst of 20 reads (STARVE path off, CPU requesting): grants 8, CPU slot, 8, slot,
//    4; dma_rvalid pulses RD_LAT after each grant, data order matches addresses.
//  - DMA read addr 3 then CPU MWRITE addr 3 0x1234 next cycle -> dma_rdata = old value,
//    mem[3]=0x1234 afterwards.
//  - RD_LAT=2 build: 3 back-to-back DMA reads -> 3 consecutive rvalid pulses starting 2 cycles
//    after first grant.

Source files
------------

// File: rtl/mem_pkg.sv
// Memory command encodings and arbiter state shared by the CPU memory path.
package mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ARB,
        DMA_BURST,
        CPU_SLOT
    } arb_state_t;

    // 2'b11 is not a request
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_lat_pipe.sv
// Valid shift register tracking DMA reads until the RAM returns their data.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic valid
);

    logic [RD_LAT-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign valid = sr[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU default priority, DMA starvation bound and locked bursts.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cpu_mem_cmd,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;

    logic cpu_req;
    logic locked;
    logic arb_dma;
    logic gnt_dma;
    logic gnt_cpu;
    logic pipe_valid;

    always_comb begin
        cpu_req   = is_req(cpu_mem_cmd);
        locked    = dma_req && dma_lock;
        arb_dma   = dma_req && (!cpu_req || starve_cnt == STARVE_TOP);
        burst_nxt = burst_cnt + BW'(1);
        gnt_dma   = 1'b0;
        gnt_cpu   = 1'b0;
        case (state)
            DMA_BURST: begin
                // once the lock drops, this cycle is arbitrated normally
                gnt_dma = locked || arb_dma;
                gnt_cpu = cpu_req && !gnt_dma;
            end
            CPU_SLOT: begin
                gnt_cpu = cpu_req;
            end
            default: begin
                gnt_dma = arb_dma;
                gnt_cpu = cpu_req && !gnt_dma;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            if (gnt_dma || !dma_req) begin
                starve_cnt <= '0;
            end else if (gnt_cpu && starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                DMA_BURST: begin
                    if (locked) begin
                        burst_cnt <= burst_nxt;
                        if (burst_nxt >= BURST_TOP) begin
                            state     <= CPU_SLOT;
                            burst_cnt <= '0;
                        end
                    end else begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end
                end
                CPU_SLOT: begin
                    burst_cnt <= '0;
                    state     <= locked ? DMA_BURST : ARB;
                end
                default: begin
                    if (gnt_dma && dma_lock) begin
                        state     <= DMA_BURST;
                        burst_cnt <= BW'(1);
                    end
                end
            endcase
        end
    end

    rd_lat_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk  (clk),
        .reset(reset),
        .issue(gnt_dma && !dma_we),
        .valid(pipe_valid)
    );

    // idle cycles keep the CPU address on the RAM to preserve its fetch timing
    always_comb begin
        if (reset) begin
            ram_addr  = '0;
            ram_wdata = '0;
            ram_we    = 1'b0;
        end else if (gnt_dma) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = gnt_cpu && (cpu_mem_cmd == MWRITE);
        end
    end

    assign dma_gnt    = !reset && gnt_dma;
    assign cpu_stall  = !reset && cpu_req && !gnt_cpu;
    assign dma_rvalid = !reset && pipe_valid;
    assign dma_rdata  = dma_rvalid ? ram_rdata : '0;
    assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RD_LAT=1 and RD_LAT=2 instances on shared stimulus.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    cmd = C_NONE;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0;
    logic          dma_we = 1'b0;
    logic          dma_lock = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;

    logic [DW-1:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic          cpu_stall, dma_gnt, dma_rvalid, ram_we;

    logic [DW-1:0] l2_cpu_rdata, l2_dma_rdata, l2_ram_wdata, l2_ram_rdata;
    logic [AW-1:0] l2_ram_addr;
    logic          l2_cpu_stall, l2_dma_gnt, l2_dma_rvalid, l2_ram_we;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4), .BURST_MAX(8)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cpu_mem_cmd(cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(4), .BURST_MAX(8)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .cpu_mem_cmd(cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(l2_cpu_rdata), .cpu_stall(l2_cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(l2_dma_gnt), .dma_rvalid(l2_dma_rvalid), .dma_rdata(l2_dma_rdata),
        .ram_addr(l2_ram_addr), .ram_we(l2_ram_we), .ram_wdata(l2_ram_wdata),
        .ram_rdata(l2_ram_rdata)
    );

    // RAM models: unwritten words read back as a known address-derived pattern
    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return 16'h5A00 + {7'd0, a};
    endfunction

    logic [DW-1:0] mem1 [512];
    logic [DW-1:0] mem2 [512];
    logic [511:0]  wr1 = '0;
    logic [511:0]  wr2 = '0;
    logic [DW-1:0] rd1, rd2a, rd2b;

    always @(posedge clk) begin
        rd1 <= wr1[ram_addr] ? mem1[ram_addr] : f(ram_addr);
        if (ram_we) begin
            mem1[ram_addr] <= ram_wdata;
            wr1[ram_addr]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        rd2a <= wr2[l2_ram_addr] ? mem2[l2_ram_addr] : f(l2_ram_addr);
        rd2b <= rd2a;
        if (l2_ram_we) begin
            mem2[l2_ram_addr] <= l2_ram_wdata;
            wr2[l2_ram_addr]  <= 1'b1;
        end
    end

    assign ram_rdata    = rd1;
    assign l2_ram_rdata = rd2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int gcnt;
        int rcnt;
        logic pg;
        logic eg;

        // reset state
        mid();
        chk("rst_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
        next();
        next();
        reset = 1'b0;

        // DMA read in flight, then reset for 2 cycles
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'd7;
        mid();
        chk("inflight_gnt", 32'(dma_gnt), 32'd1);
        next();
        dma_req = 1'b0; reset = 1'b1;
        cmd = C_READ; cpu_addr = 9'd5;
        mid();
        chk("rst1_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst1_gnt", 32'(dma_gnt), 32'd0);
        chk("rst1_stall", 32'(cpu_stall), 32'd0);
        chk("rst1_addr", 32'(ram_addr), 32'd0);
        chk("rst1_we", 32'(ram_we), 32'd0);
        chk("rst1_rvalid2", 32'(l2_dma_rvalid), 32'd0);
        next();
        mid();
        chk("rst2_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst2_rvalid2", 32'(l2_dma_rvalid), 32'd0);
        next();
        reset = 1'b0;

        // CPU read alone
        mid();
        chk("cpu_addr", 32'(ram_addr), 32'd5);
        chk("cpu_we", 32'(ram_we), 32'd0);
        chk("cpu_stall", 32'(cpu_stall), 32'd0);
        chk("cpu_gnt", 32'(dma_gnt), 32'd0);
        chk("cpu_rvalid", 32'(dma_rvalid), 32'd0);
        next();

        // DMA write alone
        cmd = C_NONE;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'd9; dma_wdata = 16'hBEEF;
        mid();
        chk("dwr_gnt", 32'(dma_gnt), 32'd1);
        chk("dwr_we", 32'(ram_we), 32'd1);
        chk("dwr_addr", 32'(ram_addr), 32'd9);
        chk("dwr_data", 32'(ram_wdata), 32'hBEEF);
        next();
        dma_req = 1'b0; dma_we = 1'b0;
        mid();
        chk("dwr_mem9", 32'(mem1[9]), 32'hBEEF);
        chk("dwr_gnt_off", 32'(dma_gnt), 32'd0);
        next();

        // contention: CPU wins 4, DMA forced through on the 5th
        cmd = C_READ; cpu_addr = 9'd5;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h10;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk($sformatf("starve_gnt%0d", i), 32'(dma_gnt), 32'(i % 5 == 4));
            chk($sformatf("starve_stall%0d", i), 32'(cpu_stall), 32'(i % 5 == 4));
            next();
        end
        dma_req = 1'b0; cmd = C_NONE;
        mid();
        chk("starve_rvalid", 32'(dma_rvalid), 32'd1);
        chk("starve_rdata", 32'(dma_rdata), 32'(f(9'h10)));
        next();

        // locked burst of 20 reads against a busy CPU: 8, slot, 8, slot, 4
        gcnt = 0; rcnt = 0; pg = 1'b0;
        for (int c = 0; c < 23; c++) begin
            cmd = (c == 0) ? C_NONE : C_READ;
            dma_req = (gcnt < 20);
            dma_lock = 1'b1; dma_we = 1'b0;
            dma_addr = 9'(9'h40 + gcnt);
            mid();
            eg = (gcnt < 20) && (c != 8) && (c != 17);
            chk($sformatf("burst_gnt%0d", c), 32'(dma_gnt), 32'(eg));
            chk($sformatf("burst_stall%0d", c), 32'(cpu_stall), 32'((c != 0) && eg));
            chk($sformatf("burst_rvalid%0d", c), 32'(dma_rvalid), 32'(pg));
            if (pg) begin
                chk($sformatf("burst_rdata%0d", c), 32'(dma_rdata), 32'(f(9'(9'h40 + rcnt))));
                rcnt++;
            end
            pg = eg;
            if (eg) gcnt++;
            next();
        end
        dma_lock = 1'b0;
        cmd = C_NONE;

        // DMA read of addr 3 followed by CPU write of addr 3
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'd3;
        mid();
        chk("raw_gnt", 32'(dma_gnt), 32'd1);
        next();
        dma_req = 1'b0;
        cmd = C_WRITE; cpu_addr = 9'd3; cpu_wdata = 16'h1234;
        mid();
        chk("raw_we", 32'(ram_we), 32'd1);
        chk("raw_addr", 32'(ram_addr), 32'd3);
        chk("raw_stall", 32'(cpu_stall), 32'd0);
        chk("raw_rvalid", 32'(dma_rvalid), 32'd1);
        chk("raw_rdata", 32'(dma_rdata), 32'(f(9'd3)));
        next();
        cmd = C_NONE;
        mid();
        chk("raw_mem3", 32'(mem1[3]), 32'h1234);
        next();

        // 3 back-to-back DMA reads on both latencies
        for (int c = 0; c < 6; c++) begin
            dma_req = (c < 3); dma_we = 1'b0;
            dma_addr = 9'(9'h20 + c);
            mid();
            chk($sformatf("b2b_gnt%0d", c), 32'(dma_gnt), 32'(c < 3));
            chk($sformatf("b2b_gnt2_%0d", c), 32'(l2_dma_gnt), 32'(c < 3));
            chk($sformatf("b2b_rv1_%0d", c), 32'(dma_rvalid), 32'(c >= 1 && c <= 3));
            chk($sformatf("b2b_rv2_%0d", c), 32'(l2_dma_rvalid), 32'(c >= 2 && c <= 4));
            if (c >= 1 && c <= 3)
                chk($sformatf("b2b_rd1_%0d", c), 32'(dma_rdata), 32'(f(9'(9'h20 + c - 1))));
            if (c >= 2 && c <= 4)
                chk($sformatf("b2b_rd2_%0d", c), 32'(l2_dma_rdata), 32'(f(9'(9'h20 + c - 2))));
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
